// File: rtl/gate_sweep_pkg.sv
// rtl/gate_sweep_pkg.sv - shared types and truth-table helpers for the gate sweep controller
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        FINISH = 2'd2
    } sweep_state_e;

    localparam int NUM_VEC = 8;

    // Vector index bits map straight onto {a,b,c}
    function automatic logic [2:0] idx_to_abc(input logic [2:0] idx);
        return idx;
    endfunction

    // Returns {t0,t1,t2} for the AND/OR/NOT datapath
    function automatic logic [2:0] expected_t(input logic a, input logic b, input logic c);
        return {a & b, a | b, ~c};
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_dwell_timer.sv
// rtl/gate_sweep_ctrl_dwell_timer.sv - per-vector dwell counter flagging the sample cycle
module sweep_dwell_timer #(
    parameter int DWELL = 20,
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic last_cycle_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_cycle_o = enable_i && (cnt_q == CNT_W'(DWELL - 1));

endmodule

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps all {a,b,c} vectors through the gate datapath and checks results
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int DWELL = 20,
    parameter int CNT_W = $clog2(DWELL)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       t0,
    input  logic       t1,
    input  logic       t2,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] vec_idx,
    output logic [7:0] err_vec,
    output logic [3:0] err_count
);

    sweep_state_e state_q, state_d;
    logic [2:0]   vec_q, vec_d;
    logic [2:0]   abc_q, abc_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pass_q, pass_d;
    logic [7:0]   err_vec_q, err_vec_d;
    logic [3:0]   err_count_q, err_count_d;
    logic         last_cycle;
    logic         mismatch;

    // Counter is held at zero outside DRIVE and restarts after each sample
    sweep_dwell_timer #(
        .DWELL (DWELL),
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      ((state_q != DRIVE) || last_cycle),
        .enable_i     (state_q == DRIVE),
        .last_cycle_o (last_cycle)
    );

    assign mismatch = ({t0, t1, t2} != expected_t(abc_q[2], abc_q[1], abc_q[0]));

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        abc_d       = abc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_vec_d   = err_vec_q;
        err_count_d = err_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    err_vec_d   = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    vec_d       = '0;
                    abc_d       = idx_to_abc(3'd0);
                    busy_d      = 1'b1;
                    state_d     = DRIVE;
                end
            end
            DRIVE: begin
                // Abort takes priority over a coincident final sample
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    abc_d   = '0;
                    vec_d   = '0;
                    pass_d  = 1'b0;
                end else if (last_cycle) begin
                    if (mismatch) begin
                        err_vec_d[vec_q] = 1'b1;
                        err_count_d      = err_count_q + 4'd1;
                    end
                    if (vec_q != 3'(NUM_VEC - 1)) begin
                        vec_d = vec_q + 3'd1;
                        abc_d = idx_to_abc(vec_q + 3'd1);
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = (err_vec_q == 8'h00);
                busy_d  = 1'b0;
                abc_d   = '0;
                vec_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            abc_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_vec_q   <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            abc_q       <= abc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_vec_q   <= err_vec_d;
            err_count_q <= err_count_d;
        end
    end

    assign a         = abc_q[2];
    assign b         = abc_q[1];
    assign c         = abc_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign vec_idx   = vec_q;
    assign err_vec   = err_vec_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb/tb_gate_sweep_ctrl.sv - self-checking bench for gate_sweep_ctrl with a faultable gate model
module tb_gate_sweep_ctrl;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       t0, t1, t2;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [2:0] vec_idx;
    logic [7:0] err_vec;
    logic [3:0] err_count;

    int fault = 0;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int         fault;
        int         restart_at;
        logic [7:0] exp_err_vec;
        logic [3:0] exp_err_count;
        logic       exp_pass;
    } sweep_vec_t;

    sweep_vec_t tbl[4];

    always #5 clk = ~clk;

    // Gate datapath model; fault 1 = t0 stuck-at-0, fault 2 = t2 stuck-at-1
    always_comb begin
        t0 = (fault == 1) ? 1'b0 : (a & b);
        t1 = a | b;
        t2 = (fault == 2) ? 1'b1 : ~c;
    end

    gate_sweep_ctrl #(.DWELL(DWELL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .t0        (t0),
        .t1        (t1),
        .t2        (t2),
        .a         (a),
        .b         (b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .vec_idx   (vec_idx),
        .err_vec   (err_vec),
        .err_count (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_abc"}, {a, b, c}, 0);
        chk({tag, "_vec_idx"}, vec_idx, 0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_sweep(input sweep_vec_t v);
        int         done_seen;
        int         done_n;
        logic [2:0] ev;
        fault     = v.fault;
        done_seen = 0;
        done_n    = -1;
        pulse_start();
        for (int n = 0; n <= 8 * DWELL + 6; n++) begin
            if (n > 0) @(negedge clk);
            start = (n == v.restart_at) ? 1'b1 : 1'b0;
            if (n < 8 * DWELL && (n % DWELL) == 0) begin
                ev = 3'(n / DWELL);
                chk("abc_step", {a, b, c}, ev);
                chk("vec_idx_step", vec_idx, ev);
                chk("busy_running", busy, 1);
            end
            chk("done_busy_exclusive", done & busy, 0);
            if (done) begin
                done_seen++;
                done_n = n;
            end
        end
        start = 1'b0;
        chk("done_count", done_seen, 1);
        chk("done_latency", done_n, 8 * DWELL + 1);
        chk("err_vec", err_vec, v.exp_err_vec);
        chk("err_count", err_count, v.exp_err_count);
        chk("pass", pass, v.exp_pass);
        chk_idle_outputs("post_sweep");
    endtask

    initial begin
        int done_seen;
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b0;

        // Reset held with start asserted
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_pass", pass, 0);
        chk("reset_err_vec", err_vec, 0);
        chk("reset_err_count", err_count, 0);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outputs("after_reset");

        tbl[0] = '{fault: 0, restart_at: -1, exp_err_vec: 8'h00, exp_err_count: 4'd0, exp_pass: 1'b1};
        tbl[1] = '{fault: 1, restart_at: -1, exp_err_vec: 8'hC0, exp_err_count: 4'd2, exp_pass: 1'b0};
        tbl[2] = '{fault: 2, restart_at: -1, exp_err_vec: 8'hAA, exp_err_count: 4'd4, exp_pass: 1'b0};
        tbl[3] = '{fault: 0, restart_at: 10, exp_err_vec: 8'h00, exp_err_count: 4'd0, exp_pass: 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_sweep(tbl[i]);
        end

        // Abort while vector 3 is driven
        fault = 0;
        pulse_start();
        repeat (12) @(negedge clk);
        chk("abort_pre_vec_idx", vec_idx, 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle_outputs("abort");
        chk("abort_pass", pass, 0);
        done_seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_stays_idle", busy, 0);
        run_sweep(tbl[0]);

        // Asynchronous reset mid-sweep at vector 5
        fault = 2;
        pulse_start();
        repeat (20) @(negedge clk);
        chk("midrst_pre_vec_idx", vec_idx, 5);
        chk("midrst_pre_err_vec", err_vec, 8'h0A);
        chk("midrst_pre_err_count", err_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("midrst");
        chk("midrst_err_vec", err_vec, 0);
        chk("midrst_err_count", err_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        fault = 0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("midrst_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
